// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: fields decoded on the input side, registered with 1-cycle latency.
// Output register plus one skid entry; in_ready is registered occupancy only, never combinational from out_ready.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int PC_WIDTH = XLEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instruction,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [11:0]         out_class,
  output logic [XLEN-1:0]     out_immediate,
  output logic                out_imm_valid,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [4:0]          out_rd,
  output logic                out_rs1_valid,
  output logic                out_rs2_valid,
  output logic                out_rd_valid,
  output logic [2:0]          out_funct3,
  output logic [6:0]          out_funct7,
  output logic                out_illegal
);

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [11:0]         cls;
    logic [XLEN-1:0]     imm;
    logic                imm_valid;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic                rs1_valid;
    logic                rs2_valid;
    logic                rd_valid;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic                illegal;
  } dec_t;

  logic [31:0]     ins;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            fmt_r, fmt_i, fmt_s, fmt_b, fmt_u, fmt_j;
  logic            bad, is_shift, shamt6;
  dec_t            dec;

  assign ins   = in_instruction;
  assign imm_i = XLEN'($signed(ins[31:20]));
  assign imm_s = XLEN'($signed({ins[31:25], ins[11:7]}));
  assign imm_b = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({ins[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));

  always_comb begin
    dec        = '0;
    dec.pc     = in_pc;
    dec.rs1    = ins[19:15];
    dec.rs2    = ins[24:20];
    dec.rd     = ins[11:7];
    dec.funct3 = ins[14:12];
    fmt_r = 1'b0; fmt_i = 1'b0; fmt_s = 1'b0;
    fmt_b = 1'b0; fmt_u = 1'b0; fmt_j = 1'b0;
    bad   = 1'b0;
    // Every listed opcode ends in 2'b11, so a compressed encoding falls into the default arm.
    case (ins[6:0])
      OPC_OP:     begin dec.cls[0] = 1'b1; fmt_r = 1'b1; end
      OPC_OP_IMM: begin dec.cls[1] = 1'b1; fmt_i = 1'b1; end
      OPC_LOAD:   begin dec.cls[2] = 1'b1; fmt_i = 1'b1; end
      OPC_STORE:  begin dec.cls[3] = 1'b1; fmt_s = 1'b1; end
      OPC_BRANCH: begin dec.cls[4] = 1'b1; fmt_b = 1'b1; end
      OPC_JAL:    begin dec.cls[5] = 1'b1; fmt_j = 1'b1; end
      OPC_JALR:   begin dec.cls[6] = 1'b1; fmt_i = 1'b1; end
      OPC_LUI:    begin dec.cls[7] = 1'b1; fmt_u = 1'b1; end
      OPC_AUIPC:  begin dec.cls[8] = 1'b1; fmt_u = 1'b1; end
      OPC_SYSTEM: begin dec.cls[9] = 1'b1; fmt_i = 1'b1; end
      OPC_OP_IMM_32: begin
        if (XLEN == 64) begin dec.cls[10] = 1'b1; fmt_i = 1'b1; end
        else            bad = 1'b1;
      end
      OPC_OP_32: begin
        if (XLEN == 64) begin dec.cls[11] = 1'b1; fmt_r = 1'b1; end
        else            bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase

    is_shift = (dec.cls[1] | dec.cls[10]) && (ins[13:12] == 2'b01);
    shamt6   = (XLEN == 64) && dec.cls[1];

    unique case (1'b1)
      fmt_i:   dec.imm = is_shift ? (shamt6 ? XLEN'(ins[25:20]) : XLEN'(ins[24:20])) : imm_i;
      fmt_s:   dec.imm = imm_s;
      fmt_b:   dec.imm = imm_b;
      fmt_u:   dec.imm = imm_u;
      fmt_j:   dec.imm = imm_j;
      default: dec.imm = '0;
    endcase

    if (fmt_r)         dec.funct7 = ins[31:25];
    else if (is_shift) dec.funct7 = {ins[31:26], shamt6 ? 1'b0 : ins[25]};

    if (is_shift && ((!shamt6 && ins[25]) || (ins[31:26] != 6'h00 && ins[31:26] != 6'h10)))
      bad = 1'b1;

    dec.rs1_valid = fmt_r | fmt_i | fmt_s | fmt_b;
    dec.rs2_valid = fmt_r | fmt_s | fmt_b;
    dec.rd_valid  = (fmt_r | fmt_i | fmt_u | fmt_j) && (ins[11:7] != 5'd0);
    dec.imm_valid = fmt_i | fmt_s | fmt_b | fmt_u | fmt_j;

    if (bad) begin
      dec.cls       = '0;
      dec.imm       = '0;
      dec.funct7    = '0;
      dec.imm_valid = 1'b0;
      dec.rs1_valid = 1'b0;
      dec.rs2_valid = 1'b0;
      dec.rd_valid  = 1'b0;
    end
    dec.illegal = bad;
  end

  dec_t out_q, skid_q;
  logic out_vld_q, skid_full_q;
  logic accept, emit;

  assign in_ready  = !rst && !skid_full_q;
  assign out_valid = out_vld_q;
  assign accept    = in_valid && in_ready;
  assign emit      = out_vld_q && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      skid_q      <= '0;
      out_vld_q   <= 1'b0;
      skid_full_q <= 1'b0;
    end else if (flush) begin
      out_vld_q   <= 1'b0;
      skid_full_q <= 1'b0;
    end else if (!out_vld_q || emit) begin
      if (skid_full_q) begin
        out_q       <= skid_q;
        out_vld_q   <= 1'b1;
        skid_full_q <= accept;
        if (accept) skid_q <= dec;
      end else begin
        out_vld_q <= accept;
        if (accept) out_q <= dec;
      end
    end else if (accept) begin
      skid_q      <= dec;
      skid_full_q <= 1'b1;
    end
  end

  assign out_pc        = out_q.pc;
  assign out_class     = out_q.cls;
  assign out_immediate = out_q.imm;
  assign out_imm_valid = out_q.imm_valid;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_rd        = out_q.rd;
  assign out_rs1_valid = out_q.rs1_valid;
  assign out_rs2_valid = out_q.rs2_valid;
  assign out_rd_valid  = out_q.rd_valid;
  assign out_funct3    = out_q.funct3;
  assign out_funct7    = out_q.funct7;
  assign out_illegal   = out_q.illegal;

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, flow-controlled RV32I/RV64I instruction decode stage. It accepts fetched instruction words with their PC over a valid/ready handshake and produces fully decoded fields one cycle later. Decoded fields include a one-hot opcode class, an XLEN-wide sign-extended immediate, register specifiers with valid flags, funct fields and an illegal-instruction flag. It sits between fetch and register read, and a 2-entry skid buffer lets it absorb downstream stalls without a combinational ready path.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. Sets immediate/PC width, shamt width and RV64-only opcodes.
- PC_WIDTH, XLEN, width of in_pc/out_pc.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  discard all held and incoming instructions this cycle.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  stage can accept; registered (no comb path from out_ready).
- in_instruction  input  32  raw instruction word.
- in_pc  input  PC_WIDTH  instruction address.
- out_valid  output  1  decoded instruction present.
- out_ready  input  1  downstream accepts.
- out_pc  output  PC_WIDTH  PC of decoded instruction.
- out_class  output  12  one-hot: [0] OP, [1] OP-IMM, [2] LOAD, [3] STORE, [4] BRANCH, [5] JAL, [6] JALR, [7] LUI, [8] AUIPC, [9] SYSTEM, [10] OP-IMM-32, [11] OP-32. Bits 10/11 are only ever set when XLEN=64.
- out_immediate  output  XLEN  decoded immediate.
- out_imm_valid  output  1  immediate meaningful.
- out_rs1, out_rs2, out_rd  output  5 each  register specifiers.
- out_rs1_valid, out_rs2_valid, out_rd_valid  output  1 each  specifier used.
- out_funct3  output  3; out_funct7  output  7.
- out_illegal  output  1  instruction unrecognised or malformed.

## Operation
- Format mapping:
  - R: OP, OP-32.
  - I: OP-IMM, OP-IMM-32, LOAD, JALR, SYSTEM.
  - S: STORE. B: BRANCH. U: LUI, AUIPC. J: JAL.
- Immediates follow the RV base encodings and are sign-extended from bit 31 to XLEN. U-type is {instr[31:12],12'b0} sign-extended to XLEN. B/J bit 0 is 0.
- Shift-immediates (OP-IMM or OP-IMM-32 with funct3 = 1 or 5):
  - Immediate is zero-extended shamt. shamt = instr[24:20] when XLEN=32 or OP-IMM-32; shamt = instr[25:20] for OP-IMM when XLEN=64.
  - out_funct7 = instr[31:25], with bit 25 forced 0 when the shamt is 6 bits.
- Other OP-IMM: out_funct7 = 0. R-type: out_funct7 = instr[31:25]. All other classes: out_funct7 = 0.
- Valid flags:
  - rs1_valid: R/I/S/B.
  - rs2_valid: R/S/B.
  - rd_valid: R/I/U/J, and forced 0 when rd == 0.
  - imm_valid: all except R.
- out_illegal = 1 (and out_class = 0, all valid flags 0) when any of the following holds:
  - instr[1:0] != 2'b11;
  - the opcode is unlisted;
  - XLEN=32 and the opcode is OP-IMM-32/OP-32;
  - a shift-immediate has a shamt bit beyond XLEN range set (instr[25] when 5-bit);
  - a shift-immediate has funct7 (excluding shamt bits) other than 0x00/0x20.
- Illegal instructions still flow through the pipeline in order; they are never dropped.
- Buffering is an output register plus one skid register.
  - Accept when in_valid && in_ready. Emit when out_valid && out_ready.
  - Skid fills only when the output register is full and not draining while an accept occurs.
  - in_ready = !skid_full.
- Flush: out_valid and skid are cleared next edge; any accept in the same cycle is discarded; in_ready = 1 next cycle.
- Reset: out_valid = 0, skid empty, in_ready = 0 while rst is high and 1 the cycle after. All out_* data fields reset to 0.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is visible at out_* after edge N (output register empty or draining).
- Throughput is 1 instruction/cycle with out_ready held high.
- out_* data is stable while out_valid && !out_ready. Order is strictly FIFO.
- Precedence: rst > flush > handshakes.
- Simultaneous accept and emit with the skid full: skid moves to the output register and the new word goes to the skid. This cannot occur because in_ready = 0 when the skid is full.
- Decode logic sits on the input side (decode before register); no decode logic is permitted between registers and outputs.

## Test plan
- XLEN=32, in 0xFFF00093 (addi x1,x0,-1) -> next cycle out_class[1]=1, imm 0xFFFFFFFF, rd=1, rd_valid=1, rs1=0, rs1_valid=1, rs2_valid=0, illegal=0.
- XLEN=32, in 0x0080006F (jal x0,8) -> out_class[5]=1, imm 0x00000008, rd_valid=0 (rd=x0).
- in 0x02009093 (slli x1,x1,32):
  - XLEN=32 -> illegal=1, class 0.
  - XLEN=64 -> class[1], imm 32, funct7 0x00, illegal=0.
- Backpressure: hold out_ready=0 and offer 3 words (PC 0,4,8) -> in_ready falls after 2 accepts. Release out_ready -> PCs 0,4,8 emerge in order on consecutive cycles with no loss or duplication.
- Flush with 2 held and in_valid high -> next cycle out_valid=0, in_ready=1; the word offered in the flush cycle never appears.
- Assert rst mid-stream with 2 held -> out_valid=0 and in_ready=0 during rst; after release, in_ready=1 and the first new word decodes normally after 1 cycle.
